// File: rtl/sync_fifo_flags_if.sv
// Handshake and status bundle for sync_fifo_flags.
// The master side is the producer/consumer; the slave side is the FIFO itself.
interface sync_fifo_flags_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
);
    localparam int ADDR_WIDTH = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] i_wr_data;
    logic                  i_wr_en;
    logic                  i_rd_en;
    logic                  i_clr_err;
    logic [DATA_WIDTH-1:0] o_rd_data;
    logic                  o_rd_valid;
    logic                  o_Full_Flag;
    logic                  o_Empty_Flag;
    logic                  o_Almost_Full;
    logic                  o_Almost_Empty;
    logic [ADDR_WIDTH:0]   o_count;
    logic                  o_Overflow;
    logic                  o_Underflow;

    modport master (
        output i_wr_data, i_wr_en, i_rd_en, i_clr_err,
        input  o_rd_data, o_rd_valid, o_Full_Flag, o_Empty_Flag,
        input  o_Almost_Full, o_Almost_Empty, o_count,
        input  o_Overflow, o_Underflow
    );

    modport slave (
        input  i_wr_data, i_wr_en, i_rd_en, i_clr_err,
        output o_rd_data, o_rd_valid, o_Full_Flag, o_Empty_Flag,
        output o_Almost_Full, o_Almost_Empty, o_count,
        output o_Overflow, o_Underflow
    );
endinterface

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with fill count, almost-full/empty thresholds,
// optional first-word-fall-through and sticky overflow/underflow flags.
module sync_fifo_flags #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int AF_LEVEL   = DEPTH - 2,
    parameter int AE_LEVEL   = 2,
    parameter bit FWFT       = 1'b0
) (
    input logic              i_clk,
    input logic              i_RST,
    sync_fifo_flags_if.slave bus
);
    localparam int ADDR_WIDTH = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH:0] ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH:0]   wr_ptr;
    logic [ADDR_WIDTH:0]   rd_ptr;
    logic [ADDR_WIDTH:0]   count;
    logic [ADDR_WIDTH:0]   count_nxt;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic                  overflow;
    logic                  underflow;
    logic                  rd_valid;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [DATA_WIDTH-1:0] head;
    logic                  wr_ok;
    logic                  rd_ok;
    logic                  wr_rej;
    logic                  rd_rej;

    // A pop frees a slot in the same cycle, so a full FIFO still takes
    // a write when it is read at the same time.
    assign rd_ok  = bus.i_rd_en & ~empty;
    assign wr_ok  = bus.i_wr_en & (~full | rd_ok);
    assign wr_rej = bus.i_wr_en & ~wr_ok;
    assign rd_rej = bus.i_rd_en & ~rd_ok;

    // Next fill level; the flags are registered from this value.
    always_comb begin
        count_nxt = count;
        unique case ({wr_ok, rd_ok})
            2'b10:   count_nxt = count + ONE;
            2'b01:   count_nxt = count - ONE;
            default: count_nxt = count;
        endcase
    end

    // Storage array; deliberately left out of reset.
    always_ff @(posedge i_clk) begin
        if (wr_ok) begin
            mem[wr_ptr[ADDR_WIDTH-1:0]] <= bus.i_wr_data;
        end
    end

    // Pointers, count, flags, sticky errors and the registered read port.
    always_ff @(posedge i_clk or posedge i_RST) begin
        if (i_RST) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
            rd_valid     <= 1'b0;
            rd_data      <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + ONE;
            end
            if (rd_ok) begin
                rd_ptr  <= rd_ptr + ONE;
                rd_data <= mem[rd_ptr[ADDR_WIDTH-1:0]];
            end
            count        <= count_nxt;
            full         <= (int'(count_nxt) == DEPTH);
            empty        <= (count_nxt == '0);
            almost_full  <= (int'(count_nxt) >= AF_LEVEL);
            almost_empty <= (int'(count_nxt) <= AE_LEVEL);
            // A new error in the clearing cycle keeps the flag set.
            overflow     <= (overflow & ~bus.i_clr_err) | wr_rej;
            underflow    <= (underflow & ~bus.i_clr_err) | rd_rej;
            rd_valid     <= FWFT ? (count_nxt != '0) : rd_ok;
        end
    end

    // FWFT head word comes straight from the array, zero while empty.
    always_comb begin
        head = '0;
        if (!empty) begin
            head = mem[rd_ptr[ADDR_WIDTH-1:0]];
        end
    end

    assign bus.o_rd_data      = FWFT ? head : rd_data;
    assign bus.o_rd_valid     = rd_valid;
    assign bus.o_Full_Flag    = full;
    assign bus.o_Empty_Flag   = empty;
    assign bus.o_Almost_Full  = almost_full;
    assign bus.o_Almost_Empty = almost_empty;
    assign bus.o_count        = count;
    assign bus.o_Overflow     = overflow;
    assign bus.o_Underflow    = underflow;
endmodule

// File: tb/tb_sync_fifo_flags.sv
// Bench for sync_fifo_flags: a standard-read and an FWFT instance share
// stimulus and are checked against a queue model plus fixed vectors.
module tb_sync_fifo_flags;
    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AF    = DEPTH - 2;
    localparam int AE    = 2;

    logic clk = 1'b0;
    logic rst;
    logic wr_en;
    logic rd_en;
    logic clr;
    logic [DW-1:0] wr_data;

    always #5 clk = ~clk;

    sync_fifo_flags_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bs ();
    sync_fifo_flags_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bf ();

    assign bs.i_wr_data = wr_data;
    assign bs.i_wr_en   = wr_en;
    assign bs.i_rd_en   = rd_en;
    assign bs.i_clr_err = clr;
    assign bf.i_wr_data = wr_data;
    assign bf.i_wr_en   = wr_en;
    assign bf.i_rd_en   = rd_en;
    assign bf.i_clr_err = clr;

    sync_fifo_flags #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(1'b0)) u_std (
        .i_clk (clk),
        .i_RST (rst),
        .bus   (bs.slave)
    );

    sync_fifo_flags #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(1'b1)) u_fwft (
        .i_clk (clk),
        .i_RST (rst),
        .bus   (bf.slave)
    );

    // Reference model: a plain queue plus the sticky bits.
    logic [DW-1:0] q [$];
    bit            m_ovf;
    bit            m_unf;
    bit            m_valid;
    logic [DW-1:0] m_rdata;

    int errs   = 0;
    int checks = 0;

    task automatic model_reset();
        q.delete();
        m_ovf   = 0;
        m_unf   = 0;
        m_valid = 0;
        m_rdata = '0;
    endtask

    task automatic model_edge();
        bit r_ok;
        bit w_ok;
        r_ok = rd_en && (q.size() != 0);
        w_ok = wr_en && ((q.size() < DEPTH) || r_ok);
        m_ovf = (m_ovf && !clr) || (wr_en && !w_ok);
        m_unf = (m_unf && !clr) || (rd_en && !r_ok);
        if (r_ok) begin
            m_rdata = q.pop_front();
            m_valid = 1;
        end else begin
            m_valid = 0;
        end
        if (w_ok) q.push_back(wr_data);
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_model();
        int sz;
        sz = q.size();
        chk("std_count", bs.o_count, sz);
        chk("std_full",  bs.o_Full_Flag, sz == DEPTH);
        chk("std_empty", bs.o_Empty_Flag, sz == 0);
        chk("std_af",    bs.o_Almost_Full, sz >= AF);
        chk("std_ae",    bs.o_Almost_Empty, sz <= AE);
        chk("std_ovf",   bs.o_Overflow, m_ovf);
        chk("std_unf",   bs.o_Underflow, m_unf);
        chk("std_valid", bs.o_rd_valid, m_valid);
        chk("std_data",  bs.o_rd_data, m_rdata);
        chk("fw_count",  bf.o_count, sz);
        chk("fw_full",   bf.o_Full_Flag, sz == DEPTH);
        chk("fw_empty",  bf.o_Empty_Flag, sz == 0);
        chk("fw_af",     bf.o_Almost_Full, sz >= AF);
        chk("fw_ae",     bf.o_Almost_Empty, sz <= AE);
        chk("fw_ovf",    bf.o_Overflow, m_ovf);
        chk("fw_unf",    bf.o_Underflow, m_unf);
        chk("fw_valid",  bf.o_rd_valid, sz != 0);
        chk("fw_data",   bf.o_rd_data, (sz != 0) ? q[0] : 8'h00);
    endtask

    // Drive one cycle of inputs, advance the model at the edge, sample #1 later.
    task automatic step(bit w, logic [DW-1:0] d, bit r, bit c);
        wr_en   = w;
        wr_data = d;
        rd_en   = r;
        clr     = c;
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic chk_reset_state(string tag);
        chk({tag, "_count"}, bs.o_count, 0);
        chk({tag, "_empty"}, bs.o_Empty_Flag, 1);
        chk({tag, "_ae"},    bs.o_Almost_Empty, 1);
        chk({tag, "_full"},  bs.o_Full_Flag, 0);
        chk({tag, "_af"},    bs.o_Almost_Full, 0);
        chk({tag, "_ovf"},   bs.o_Overflow, 0);
        chk({tag, "_unf"},   bs.o_Underflow, 0);
        chk({tag, "_valid"}, bs.o_rd_valid, 0);
        chk({tag, "_data"},  bs.o_rd_data, 0);
        chk({tag, "_fwval"}, bf.o_rd_valid, 0);
        chk({tag, "_fwdat"}, bf.o_rd_data, 0);
        chk({tag, "_fwcnt"}, bf.o_count, 0);
    endtask

    typedef struct {
        bit            wr;
        logic [DW-1:0] d;
        bit            rd;
        bit            c;
        int            cnt;
        bit            empty;
        bit            ae;
        bit            unf;
        bit            valid;
        logic [DW-1:0] data;
    } vec_t;

    vec_t tbl [10];

    initial begin
        int pw;
        int pr;
        int sel;

        // wr d rd clr | count empty ae unf valid data (standard instance)
        tbl[0] = '{1, 8'h01, 0, 0, 1, 0, 1, 0, 0, 8'h00};
        tbl[1] = '{1, 8'h02, 0, 0, 2, 0, 1, 0, 0, 8'h00};
        tbl[2] = '{0, 8'h00, 0, 0, 2, 0, 1, 0, 0, 8'h00};
        tbl[3] = '{0, 8'h00, 0, 0, 2, 0, 1, 0, 0, 8'h00};
        tbl[4] = '{0, 8'h00, 1, 0, 1, 0, 1, 0, 1, 8'h01};
        tbl[5] = '{0, 8'h00, 1, 0, 0, 1, 1, 0, 1, 8'h02};
        tbl[6] = '{0, 8'h00, 0, 0, 0, 1, 1, 0, 0, 8'h02};
        tbl[7] = '{0, 8'h00, 1, 0, 0, 1, 1, 1, 0, 8'h02};
        tbl[8] = '{0, 8'h00, 1, 0, 0, 1, 1, 1, 0, 8'h02};
        tbl[9] = '{0, 8'h00, 0, 1, 0, 1, 1, 0, 0, 8'h02};

        wr_en   = 0;
        rd_en   = 0;
        clr     = 0;
        wr_data = '0;
        rst     = 1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk_reset_state("rst");
        @(negedge clk);
        rst = 0;
        @(posedge clk);
        #1;

        // Basic write/read, underflow and clear
        foreach (tbl[i]) begin
            step(tbl[i].wr, tbl[i].d, tbl[i].rd, tbl[i].c);
            chk($sformatf("v%0d_count", i), bs.o_count, tbl[i].cnt);
            chk($sformatf("v%0d_empty", i), bs.o_Empty_Flag, tbl[i].empty);
            chk($sformatf("v%0d_ae", i),    bs.o_Almost_Empty, tbl[i].ae);
            chk($sformatf("v%0d_unf", i),   bs.o_Underflow, tbl[i].unf);
            chk($sformatf("v%0d_ovf", i),   bs.o_Overflow, 0);
            chk($sformatf("v%0d_valid", i), bs.o_rd_valid, tbl[i].valid);
            chk($sformatf("v%0d_data", i),  bs.o_rd_data, tbl[i].data);
            chk_model();
        end

        // Fill to full, then overflow
        for (int i = 1; i <= DEPTH; i++) begin
            step(1, 8'(i), 0, 0);
            chk("fill_af",   bs.o_Almost_Full, i >= 14);
            chk("fill_full", bs.o_Full_Flag, i == DEPTH);
            chk_model();
        end
        step(1, 8'hAA, 0, 0);
        chk("ovf_set",   bs.o_Overflow, 1);
        chk("ovf_count", bs.o_count, DEPTH);
        chk("ovf_head",  bf.o_rd_data, 8'h01);
        chk_model();
        step(0, 8'h00, 0, 1);
        chk("ovf_clr", bs.o_Overflow, 0);

        // Simultaneous read and write while full, then drain
        step(1, 8'h55, 1, 0);
        chk("rw_full_count", bs.o_count, DEPTH);
        chk("rw_full_ovf",   bs.o_Overflow, 0);
        chk("rw_full_data",  bs.o_rd_data, 8'h01);
        chk_model();
        for (int i = 0; i < DEPTH; i++) begin
            step(0, 8'h00, 1, 0);
            chk("drain_data",  bs.o_rd_data, (i < DEPTH - 1) ? i + 2 : 8'h55);
            chk("drain_count", bs.o_count, DEPTH - 1 - i);
            chk("drain_ae",    bs.o_Almost_Empty, (DEPTH - 1 - i) <= 2);
            chk("drain_empty", bs.o_Empty_Flag, i == DEPTH - 1);
            chk_model();
        end

        // FWFT: word written into empty FIFO appears without a read
        step(1, 8'h3C, 0, 0);
        chk("fwft_valid", bf.o_rd_valid, 1);
        chk("fwft_data",  bf.o_rd_data, 8'h3C);
        step(0, 8'h00, 0, 0);
        chk("fwft_hold",  bf.o_rd_data, 8'h3C);
        step(0, 8'h00, 1, 0);
        chk("fwft_pop_valid", bf.o_rd_valid, 0);
        chk("fwft_pop_empty", bf.o_Empty_Flag, 1);
        chk_model();

        // Asynchronous reset between edges with data held
        for (int i = 0; i < 5; i++) step(1, 8'(i * 3 + 1), 0, 0);
        chk("pre_rst_count", bs.o_count, 5);
        wr_en = 0;
        #3 rst = 1;
        #1;
        chk_reset_state("arst");
        model_reset();
        #2 rst = 0;
        step(1, 8'h77, 0, 0);
        chk("post_rst_fw", bf.o_rd_data, 8'h77);
        step(0, 8'h00, 1, 0);
        chk("post_rst_data",  bs.o_rd_data, 8'h77);
        chk("post_rst_valid", bs.o_rd_valid, 1);
        chk("post_rst_empty", bs.o_Empty_Flag, 1);
        chk_model();

        // Randomized traffic in phases biased toward fill, drain and mixed
        pw = 50;
        pr = 50;
        for (int n = 0; n < 3000; n++) begin
            if (n % 150 == 0) begin
                sel = $urandom_range(3);
                case (sel)
                    0: begin pw = 85; pr = 20; end
                    1: begin pw = 20; pr = 85; end
                    2: begin pw = 50; pr = 50; end
                    default: begin pw = 95; pr = 95; end
                endcase
            end
            step($urandom_range(99) < pw, 8'($urandom),
                 $urandom_range(99) < pr, $urandom_range(99) < 6);
            chk_model();
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/sync_fifo_flags.md
Name: sync_fifo_flags

Overview:
Single-clock, parametrised FIFO: next generation of the team's dual-clock FIFO for same-domain buffering.
Adds a fill-level count, programmable almost-full/almost-empty thresholds, and a first-word-fall-through (FWFT) mode.
Adds sticky overflow/underflow error flags.
Sits between same-clock producer/consumer blocks; no CDC synchronisers needed.

Parameters:
DATA_WIDTH, 8, width of each data word
DEPTH, 16, number of entries; must be a power of two, >= 4
ADDR_WIDTH, $clog2(DEPTH), pointer index width; derived, never overridden
AF_LEVEL, DEPTH-2, o_Almost_Full asserts when count >= AF_LEVEL
AE_LEVEL, 2, o_Almost_Empty asserts when count <= AE_LEVEL
FWFT, 0, 0 = standard read (data one cycle after i_rd_en); 1 = first-word-fall-through

Ports:
i_clk  in  1  single clock; all state on rising edge
i_RST  in  1  asynchronous, active-high reset
i_wr_data  in  DATA_WIDTH  write data
i_wr_en  in  1  write request
i_rd_en  in  1  read request (FWFT=1: acknowledge/pop of the current head)
i_clr_err  in  1  synchronous clear of the sticky error flags
o_rd_data  out  DATA_WIDTH  read data
o_rd_valid  out  1  o_rd_data holds valid data this cycle
o_Full_Flag  out  1  count == DEPTH
o_Empty_Flag  out  1  count == 0
o_Almost_Full  out  1  count >= AF_LEVEL
o_Almost_Empty  out  1  count <= AE_LEVEL
o_count  out  ADDR_WIDTH+1  current fill level, 0..DEPTH
o_Overflow  out  1  sticky: a write was attempted while full and rejected
o_Underflow  out  1  sticky: a read was attempted while empty and rejected

Behaviour:
- Reset (asynchronous, i_RST=1):
  - Pointers and count = 0; o_Empty_Flag=1, o_Almost_Empty=1.
  - o_Full_Flag=0, o_Almost_Full=0, o_Overflow=0, o_Underflow=0.
  - o_rd_valid=0, o_rd_data=0.
  - Memory contents are not reset.
  - Reset mid-operation discards all stored data immediately.
- Pointers: ADDR_WIDTH+1 bits, binary. The MSB is the wrap bit.
  - Full = same index bits and differing MSB; empty = pointers equal.
  - Index wraps DEPTH-1 -> 0 with no gap.
- Accepted operations:
  - wr_ok = i_wr_en & (~full | rd_ok).
  - rd_ok = i_rd_en & ~empty.
  - Count updates next edge: +1 for write only, -1 for read only, unchanged for both.
- Simultaneous read and write:
  - When full: both accepted; count stays DEPTH; no overflow.
  - When empty: write accepted, read rejected; o_Underflow set (standard mode and FWFT).
- Rejected operations:
  - Rejected write: memory and pointers unchanged; o_Overflow <= 1.
  - Rejected read: pointers unchanged; o_Underflow <= 1.
- Sticky errors: cleared only by reset or by i_clr_err=1. If i_clr_err and a new error occur in the same cycle, the set wins.
- Flags: all flags and o_count are registered and derive from the post-update count. No combinational path from i_wr_en/i_rd_en to the flags.
- FWFT=0:
  - o_rd_data is registered and loads mem[rd_ptr] on the edge where rd_ok.
  - o_rd_valid=1 the cycle after rd_ok, otherwise 0.
  - o_rd_data holds its last value when no read occurs.
  - Read latency: 1 cycle.
- FWFT=1:
  - o_rd_data presents the head word whenever the FIFO is non-empty.
  - o_rd_valid = ~o_Empty_Flag.
  - i_rd_en pops the head; the next head appears the following cycle.
  - A word written into an empty FIFO is visible with o_rd_valid=1 one cycle after the write edge.
- Threshold rules:
  - AF_LEVEL and AE_LEVEL are compared against the full-width count. No wrap ambiguity.
  - AF_LEVEL > DEPTH never asserts; AE_LEVEL=0 equals empty.

Test Plan:
1. Reset, then write 0x01 and 0x02; after 2 idle cycles read twice (FWFT=0) -> o_count=2 then 0; o_rd_data=0x01 then 0x02, each with o_rd_valid=1 one cycle after i_rd_en; final o_Empty_Flag=1, no errors.
2. Read 2 cycles on empty FIFO -> o_Underflow=1 after first edge, o_count stays 0, o_rd_valid=0; pulse i_clr_err -> o_Underflow=0.
3. Write 1..16 (DEPTH=16) -> o_Almost_Full rises when count reaches 14, o_Full_Flag=1 at 16; a 17th write of 0xAA -> o_Overflow=1, count 16, data unchanged.
4. Full FIFO, simultaneous write 0x55 + read -> count stays 16, no overflow; then drain 16 reads -> data 2..16, 0x55 in order; o_Almost_Empty rises at count 2; o_Empty_Flag at 0.
5. FWFT=1: write 0x3C to empty FIFO -> next cycle o_rd_valid=1, o_rd_data=0x3C without i_rd_en; pop -> o_rd_valid=0, o_Empty_Flag=1.
6. Assert i_RST asynchronously (between edges) with count=5 -> all outputs to reset values immediately, o_count=0; subsequent write/read of 0x77 succeeds normally.
